// File: rtl/sysid_info_regs.sv
// System identity and uptime register slave for the lightweight HPS bridge.
// Word map: 0 ID, 1 build timestamp, 2 uptime low (latches high half),
// 3 latched uptime high, 4 scratch, 5 control/status, 6-7 reserved (read 0).
// Bus handshake: a read strobe sampled on a clock edge produces readdata and
// readdatavalid from that same edge, so both are seen one cycle after the
// request. There is no waitrequest. Writes land on the sampling edge. A read
// and a write in the same cycle service the read and discard the write.
// PRESCALE must lie in 1..65535 and CNT_W must lie in 33..64.
module sysid_info_regs #(
    parameter logic [31:0] SYSTEM_ID       = 32'h0000_0391,
    parameter logic [31:0] BUILD_TIMESTAMP = 32'd1616605598,
    parameter int unsigned PRESCALE        = 50,
    parameter int unsigned CNT_W           = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned HI_W = CNT_W - 32;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
    localparam logic [2:0] ADDR_LO      = 3'd2;
    localparam logic [2:0] ADDR_HI      = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] ADDR_CTRL    = 3'd5;

    logic [31:0]      readdata_q, readdata_d;
    logic             readdatavalid_q, readdatavalid_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [CNT_W-1:0] uptime_q, uptime_d;
    logic [HI_W-1:0]  snapshot_q, snapshot_d;
    logic [PS_W-1:0]  prescaler_q, prescaler_d;
    logic             ovf_q, ovf_d;
    logic             enable_q, enable_d;

    logic             wr_en;
    logic             ctrl_wr;
    logic             scratch_wr;
    logic             clear;
    logic             tick;
    logic             wrap;
    logic             snap_ld;
    logic [31:0]      rd_mux;

    // Decode strobes; a coincident read wins and the write is dropped.
    always_comb begin
        wr_en      = write & ~read;
        ctrl_wr    = wr_en & (address == ADDR_CTRL);
        scratch_wr = wr_en & (address == ADDR_SCRATCH);
        clear      = ctrl_wr & writedata[1];
        tick       = enable_q & (prescaler_q == PS_LAST);
        // Clear suppresses the increment, so it also suppresses the wrap.
        wrap       = tick & ~clear & (&uptime_q);
        snap_ld    = read & (address == ADDR_LO);
    end

    // Read data mux; unused bits and reserved words read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:      rd_mux = SYSTEM_ID;
            ADDR_TSTAMP:  rd_mux = BUILD_TIMESTAMP;
            ADDR_LO:      rd_mux = uptime_q[31:0];
            ADDR_HI:      rd_mux[HI_W-1:0] = snapshot_q;
            ADDR_SCRATCH: rd_mux = scratch_q;
            ADDR_CTRL: begin
                rd_mux[0] = enable_q;
                rd_mux[8] = ovf_q;
            end
            default:      rd_mux = '0;
        endcase
    end

    // Next-state logic for the counter, control bits, scratch and read port.
    always_comb begin
        prescaler_d     = prescaler_q;
        uptime_d        = uptime_q;
        ovf_d           = ovf_q;
        enable_d        = enable_q;
        scratch_d       = scratch_q;
        snapshot_d      = snapshot_q;
        readdatavalid_d = read;
        readdata_d      = readdata_q;

        if (clear) begin
            prescaler_d = '0;
            uptime_d    = '0;
        end else if (enable_q) begin
            if (tick) begin
                prescaler_d = '0;
                uptime_d    = uptime_q + CNT_W'(1);
            end else begin
                prescaler_d = prescaler_q + PS_W'(1);
            end
        end

        // Overflow set takes priority over a same-edge write-1-to-clear.
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (ctrl_wr & writedata[8]) begin
            ovf_d = 1'b0;
        end

        if (ctrl_wr) begin
            enable_d = writedata[0];
        end

        for (int i = 0; i < 4; i++) begin
            if (scratch_wr & byteenable[i]) begin
                scratch_d[8*i +: 8] = writedata[8*i +: 8];
            end
        end

        // The low-word read captures the pre-increment high half, keeping the pair coherent.
        if (snap_ld) begin
            snapshot_d = uptime_q[CNT_W-1:32];
        end

        if (read) begin
            readdata_d = rd_mux;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            scratch_q       <= '0;
            uptime_q        <= '0;
            snapshot_q      <= '0;
            prescaler_q     <= '0;
            ovf_q           <= 1'b0;
            enable_q        <= 1'b1;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
            scratch_q       <= scratch_d;
            uptime_q        <= uptime_d;
            snapshot_q      <= snapshot_d;
            prescaler_q     <= prescaler_d;
            ovf_q           <= ovf_d;
            enable_q        <= enable_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Directed bench for sysid_info_regs: three instances with different
// prescale/width settings share clock and reset; expected read data is
// queued when a read is driven and checked when readdatavalid appears.
module tb_sysid_info_regs;

    localparam int A = 0;   // PRESCALE=4, CNT_W=64
    localparam int B = 1;   // PRESCALE=1, CNT_W=64
    localparam int C = 2;   // PRESCALE=1, CNT_W=33

    logic        clock;
    logic        reset_n;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [2:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];

    logic [31:0] rdd_a, rdd_b, rdd_c;
    logic        rdv_a, rdv_b, rdv_c;
    logic [2:0]  pend;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    int checks;
    int errors;

    sysid_info_regs #(.PRESCALE(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .address(addr[A]), .read(rd[A]),
        .write(wr[A]), .writedata(wdata[A]), .byteenable(be[A]),
        .readdata(rdd_a), .readdatavalid(rdv_a)
    );

    sysid_info_regs #(.PRESCALE(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .address(addr[B]), .read(rd[B]),
        .write(wr[B]), .writedata(wdata[B]), .byteenable(be[B]),
        .readdata(rdd_b), .readdatavalid(rdv_b)
    );

    sysid_info_regs #(.PRESCALE(1), .CNT_W(33)) dut_c (
        .clock(clock), .reset_n(reset_n), .address(addr[C]), .read(rd[C]),
        .write(wr[C]), .writedata(wdata[C]), .byteenable(be[C]),
        .readdata(rdd_c), .readdatavalid(rdv_c)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Remember which instance had a read sampled on each rising edge.
    always @(posedge clock) begin
        pend <= rd & {3{reset_n}};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Scoreboard: readdatavalid must follow exactly the accepted reads.
    task automatic mon(input int k, input logic v, input logic [31:0] d);
        logic        ev;
        logic [31:0] e;
        string       t;
        ev = pend[k] && reset_n;
        checks++;
        assert (v === ev) else begin
            errors++;
            $error("FAIL rdv_%0d: got %b expected %b", k, v, ev);
        end
        if (ev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_read_%0d: got %h expected nothing", k, d);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, d, e);
            end
        end
    endtask

    always @(negedge clock) begin
        mon(A, rdv_a, rdd_a);
        mon(B, rdv_b, rdd_b);
        mon(C, rdv_c, rdd_c);
    end

    // Driver tasks: called at a falling edge, return at the next one.
    task automatic drive(input int k, input logic r, input logic w, input logic [2:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        rd[k]    = r;
        wr[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        be[k]    = b;
        @(negedge clock);
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    task automatic do_read(input int k, input logic [2:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        drive(k, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic do_write(input int k, input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        drive(k, 1'b0, 1'b1, a, d, b);
    endtask

    task automatic do_rw(input int k, input logic [2:0] a, input logic [31:0] d, input logic [3:0] b,
                         input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        drive(k, 1'b1, 1'b1, a, d, b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        rd      = '0;
        wr      = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k]  = '0;
            wdata[k] = '0;
            be[k]    = '0;
        end
        idle(3);
        check("rst_rdd_a", rdd_a, 32'h0);
        check("rst_rdd_b", rdd_b, 32'h0);
        check("rst_rdd_c", rdd_c, 32'h0);
        reset_n = 1'b1;

        // Prescale 4: after 40 edges the counter holds 10.
        idle(40);
        do_read(A, 3'd2, 32'd10, "a_lo_40");
        do_read(A, 3'd3, 32'd0,  "a_hi_40");
        do_write(A, 3'd5, 32'h0, 4'hF);
        idle(20);
        do_read(A, 3'd2, 32'd10, "a_lo_frozen");
        do_read(A, 3'd5, 32'h0,  "a_ctrl_disabled");
        do_write(A, 3'd5, 32'h1, 4'hF);
        idle(5);
        do_write(A, 3'd5, 32'h3, 4'hF);
        do_read(A, 3'd2, 32'd0, "a_lo_after_clear");
        do_read(A, 3'd5, 32'h1, "a_ctrl_after_clear");
        idle(4);
        do_read(A, 3'd2, 32'd1, "a_lo_prescaled");

        // Identity, reserved, scratch and reset values.
        do_read(C, 3'd0, 32'h0000_0391,   "c_id");
        do_read(C, 3'd1, 32'd1616605598,  "c_tstamp");
        do_read(C, 3'd7, 32'h0,           "c_rsvd7");
        do_read(C, 3'd6, 32'h0,           "c_rsvd6");
        do_read(C, 3'd4, 32'h0,           "c_scratch_rst");
        do_read(C, 3'd5, 32'h1,           "c_ctrl_rst");
        do_read(C, 3'd3, 32'h0,           "c_hi_rst");
        do_write(C, 3'd4, 32'hDEAD_BEEF, 4'b0101);
        do_read(C, 3'd4, 32'h00AD_00EF,   "c_scratch_be");
        do_write(C, 3'd0, 32'h1234_5678, 4'hF);
        do_read(C, 3'd0, 32'h0000_0391,   "c_id_ro");
        do_write(C, 3'd7, 32'hFFFF_FFFF, 4'hF);
        do_read(C, 3'd7, 32'h0,           "c_rsvd_wr");
        do_rw(C, 3'd4, 32'h1111_1111, 4'hF, 32'h00AD_00EF, "c_rw_old");
        do_read(C, 3'd4, 32'h00AD_00EF,   "c_rw_dropped");

        // 33-bit wrap: preload all-ones while disabled (byteenable ignored at CTRL).
        do_write(C, 3'd5, 32'h0, 4'h0);
        force dut_c.uptime_q = {33{1'b1}};
        idle(1);
        release dut_c.uptime_q;
        do_write(C, 3'd5, 32'h1, 4'hF);
        do_read(C, 3'd2, 32'hFFFF_FFFF, "c_lo_at_wrap");
        do_read(C, 3'd3, 32'h1,         "c_hi_at_wrap");
        do_read(C, 3'd5, 32'h101,       "c_ctrl_ovf");
        do_write(C, 3'd5, 32'h101, 4'hF);
        do_read(C, 3'd5, 32'h1,         "c_ctrl_w1c");

        // Wrap on the same edge as write-1-to-clear: set wins.
        do_write(C, 3'd5, 32'h0, 4'hF);
        force dut_c.uptime_q = {1'b1, 32'hFFFF_FFFE};
        idle(1);
        release dut_c.uptime_q;
        do_write(C, 3'd5, 32'h1, 4'hF);
        idle(1);
        do_write(C, 3'd5, 32'h101, 4'hF);
        do_read(C, 3'd5, 32'h101, "c_ovf_set_wins");
        do_read(C, 3'd2, 32'd1,   "c_lo_after_wrap");
        idle(2);
        check("c_rdata_hold", rdd_c, 32'd1);

        // 64-bit coherency across the low-word carry.
        do_write(B, 3'd5, 32'h0, 4'hF);
        force dut_b.uptime_q = 64'h0000_0000_FFFF_FFFE;
        idle(1);
        release dut_b.uptime_q;
        do_write(B, 3'd5, 32'h1, 4'hF);
        idle(1);
        do_read(B, 3'd2, 32'hFFFF_FFFF, "b_lo_coincident");
        do_read(B, 3'd3, 32'h0,         "b_hi_coherent");
        do_read(B, 3'd2, 32'h1,         "b_lo_next");
        do_read(B, 3'd3, 32'h1,         "b_hi_next");
        do_write(B, 3'd5, 32'h3, 4'hF);
        do_read(B, 3'd3, 32'h1,         "b_hi_after_clear");
        do_read(B, 3'd2, 32'h1,         "b_lo_after_clear");
        do_read(B, 3'd5, 32'h1,         "b_ctrl_after_clear");

        // Reset between the read edge and the data cycle.
        rd[C]   = 1'b1;
        addr[C] = 3'd0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_rdv",  {31'h0, rdv_c}, 32'h0);
        check("rst_mid_rdd",  rdd_c, 32'h0);
        @(negedge clock);
        rd[C] = 1'b0;
        idle(2);
        reset_n = 1'b1;
        do_read(C, 3'd2, 32'h0, "c_lo_post_rst");
        do_read(C, 3'd4, 32'h0, "c_scratch_post_rst");
        do_read(C, 3'd5, 32'h1, "c_ctrl_post_rst");
        do_read(C, 3'd3, 32'h0, "c_hi_post_rst");
        do_read(B, 3'd3, 32'h0, "b_hi_post_rst");
        idle(3);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
- Parametrised successor to the fixed system-ID slave: Avalon-MM register slave on the lightweight bridge.
- Returns build identity words: system ID and build timestamp.
- Adds a prescaled 64-bit uptime counter with coherent hi/lo snapshot reads, a scratch register, and control/status.
- Software uses it to check that the HPS image matches the FPGA image, and as a free-running time base.

Parameters:
SYSTEM_ID  32'h0000_0391  value returned at word 0
BUILD_TIMESTAMP  32'd1616605598  value returned at word 1 (Unix seconds)
PRESCALE  50  clock cycles per uptime tick; legal range 1..65535; 50 gives 1 us at 50 MHz
CNT_W  64  uptime counter width; legal range 33..64; bits above CNT_W read 0

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address
read  in  1  read strobe, single cycle per access
write  in  1  write strobe
writedata  in  32  write data
byteenable  in  4  byte lanes for writes to SCRATCH; ignored at CTRL, where writes are full-word
readdata  out  32  registered read data
readdatavalid  out  1  high for one cycle, 1 cycle after an accepted read

Behaviour:
- Reset is asynchronous, active-low. All state clears immediately:
  - readdata=0, readdatavalid=0
  - scratch=0, uptime=0, snapshot=0, prescaler=0, ovf=0
  - enable=1
- Register map (word address):
  - 0 ID: RO, SYSTEM_ID.
  - 1 TSTAMP: RO, BUILD_TIMESTAMP.
  - 2 UPTIME_LO: RO, uptime[31:0]. The same read latches uptime[CNT_W-1:32] into snapshot.
  - 3 UPTIME_HI: RO, returns snapshot, zero-extended.
  - 4 SCRATCH: RW, byte-enabled.
  - 5 CTRL:
    - bit0 enable: RW.
    - bit1 clear: write 1 pulses clear; always reads 0.
    - bit8 ovf: sticky, write 1 to clear.
    - All other bits read 0.
  - 6, 7: reserved. Read 0; writes ignored.
- Read timing:
  - read sampled at edge N; readdata/readdatavalid valid after edge N+1. Fixed latency 1, no waitrequest.
  - readdatavalid is low on every cycle without a preceding read.
  - readdata holds its last value when not valid.
- Write timing: takes effect at the sampling edge; zero wait states. Writes to RO words are ignored.
- read and write in the same cycle: the read is serviced and the write is dropped.
- Read-write ordering:
  - A read in the cycle after a write returns the written value.
  - Back-to-back reads are supported every cycle.
- Prescaler:
  - When enable=1, prescaler counts 0..PRESCALE-1.
  - At PRESCALE-1 it returns to 0 and uptime increments by 1.
  - PRESCALE=1 means uptime increments every cycle while enabled.
  - enable=0 freezes both prescaler and uptime.
- Clear:
  - Zeroes uptime and prescaler on the write edge.
  - Clear beats a coincident increment.
  - ovf and snapshot are unaffected.
- Wrap and ovf:
  - uptime wraps from all-ones to 0 and sets ovf on that same edge.
  - If set and W1C coincide, set wins.
- UPTIME_LO read coincident with an increment:
  - LO returns the pre-increment value.
  - Snapshot latches the pre-increment high bits.
  - The pair is therefore coherent.
- Snapshot changes only on a read of word 2 (or on reset).
- Reset mid-read: readdatavalid drops immediately; the pending read is lost.

Test Plan:
- Reset, then read word 0, word 1, word 7 -> readdata 0x00000391, then 1616605598, then 0; each with readdatavalid exactly 1 cycle after read; readdatavalid=0 on all other cycles.
- Write SCRATCH 0xDEADBEEF with byteenable=4'b0101, after reset → read returns 0x00AD00EF; write word 0 with 0x12345678 → word 0 still reads 0x00000391.
- PRESCALE=4, enable=1, wait 40 cycles from reset release → UPTIME_LO read returns 10 (±0 with cycle-exact alignment). Then write CTRL=0 (disable), wait 20 cycles → value unchanged.
- Coherency, CNT_W=64, PRESCALE=1:
  - Force uptime to 0x00000000_FFFFFFFF via clear plus counting, or a bench backdoor.
  - Read LO on the edge where it increments → LO=0xFFFFFFFF; HI read later=0x00000000.
  - Next LO read → 0x00000000(+n); HI=0x00000001.
- Wrap, CNT_W=33, PRESCALE=1:
  - Run 2^33 cycles (or backdoor preload all-ones) → uptime=0 and CTRL bit8=1.
  - Write CTRL=0x101 → ovf=0, enable=1.
  - Coincident wrap and W1C → ovf stays 1.
- Write CTRL=0x3 while counting → uptime=0 on the next read, and CTRL reads 0x1. Assert read and write together on SCRATCH → old value returned, SCRATCH unchanged. Drop reset_n between read and readdatavalid → readdatavalid stays 0 and all registers hold their reset values.
